jtcontra_vtimer_adj: RTL and testbench



---
 rtl/jtcontra_vtimer_adj.sv | 154 +++++++++++++++
 tb/tb_jtcontra_vtimer_adj.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_vtimer_adj.sv
// jtcontra_vtimer_adj
// Parametrised video timing generator. From a single pixel clock enable it
// produces the pixel/line counters, the look-ahead render lines, the blanking
// and sync flags, a delayed copy of the blanking flags and a frame counter.
// The horizontal sync position can be moved at runtime by hs_ofs. The new
// offset only takes effect at the start of a frame.
//
// Ports
//   rst        asynchronous active-high reset
//   clk        system clock
//   pxl_cen    pixel clock enable; all state holds while low
//   hs_ofs     signed HS offset in pixels (-8..+7), sampled at frame start
//   hdump      current pixel, H_START..H_END
//   vdump      current line, V_START..V_END
//   vrender    vdump+1, wrapped into V_START..V_END
//   vrender1   vdump+2, wrapped into V_START..V_END
//   LHBL/LVBL  active-low horizontal/vertical blanking
//   LHBL_dly/LVBL_dly  blanking delayed by DLY pixel ticks
//   HS/VS      active-high sync
//   Hinit      high while hdump==H_END
//   Vinit      high while hdump==H_END and vdump==V_END
//   frame      frame counter, wraps at 256
module jtcontra_vtimer_adj #(
    parameter int H_START  = 0,
    parameter int H_END    = 383,
    parameter int HB_START = 279,
    parameter int HB_END   = 383,
    parameter int HS_START = 300,
    parameter int HS_END   = 332,
    parameter int V_START  = 0,
    parameter int V_END    = 263,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 250,
    parameter int VS_END   = 253,
    parameter int DLY      = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pxl_cen,
    input  logic [3:0] hs_ofs,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic       LHBL,
    output logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic       HS,
    output logic       VS,
    output logic       Hinit,
    output logic       Vinit,
    output logic [7:0] frame
);

    localparam int HLEN = H_END - H_START + 1;
    localparam int VLEN = V_END - V_START + 1;

    logic [3:0]        ofs_l;
    logic              h_wrap, v_wrap;
    logic [8:0]        h_nxt, v_nxt;
    logic signed [10:0] ofs_x, hs_a_raw, hs_b_raw;
    logic [8:0]        hs_a, hs_b;
    logic [9:0]        vr_raw, vr1_raw;
    logic [DLY-1:0]    lhbl_pipe, lvbl_pipe;

    // Bring an offset sync position back into H_START..H_END.
    function automatic logic [8:0] hfold(input logic signed [10:0] v);
        if (v > 11'(H_END))
            return 9'(v - 11'(HLEN));
        else if (v < 11'(H_START))
            return 9'(v + 11'(HLEN));
        else
            return 9'(v);
    endfunction

    assign ofs_x    = {{7{ofs_l[3]}}, ofs_l};
    assign hs_a_raw = 11'(HS_START) + ofs_x;
    assign hs_b_raw = 11'(HS_END) + ofs_x;
    assign hs_a     = hfold(hs_a_raw);
    assign hs_b     = hfold(hs_b_raw);

    // Next counter values; flags are decoded from these so that each flag
    // changes on the same edge as the counter reaching its trigger value.
    assign h_wrap = (hdump == 9'(H_END));
    assign v_wrap = h_wrap && (vdump == 9'(V_END));
    assign h_nxt  = h_wrap ? 9'(H_START) : hdump + 9'd1;
    assign v_nxt  = h_wrap ? (v_wrap ? 9'(V_START) : vdump + 9'd1) : vdump;

    assign Hinit = h_wrap;
    assign Vinit = v_wrap;

    assign vr_raw   = {1'b0, vdump} + 10'd1;
    assign vr1_raw  = {1'b0, vdump} + 10'd2;
    assign vrender  = (vr_raw  > 10'(V_END)) ? 9'(vr_raw  - 10'(VLEN)) : vr_raw[8:0];
    assign vrender1 = (vr1_raw > 10'(V_END)) ? 9'(vr1_raw - 10'(VLEN)) : vr1_raw[8:0];

    assign LHBL_dly = lhbl_pipe[DLY-1];
    assign LVBL_dly = lvbl_pipe[DLY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdump     <= 9'(H_START);
            vdump     <= 9'(V_START);
            frame     <= 8'd0;
            ofs_l     <= 4'd0;
            LHBL      <= 1'b0;
            LVBL      <= 1'b0;
            HS        <= 1'b0;
            VS        <= 1'b0;
            lhbl_pipe <= '0;
            lvbl_pipe <= '0;
        end else if (pxl_cen) begin
            hdump <= h_nxt;
            vdump <= v_nxt;
            if (v_wrap) begin
                frame <= frame + 8'd1;
                ofs_l <= hs_ofs;
            end

            if (h_nxt == 9'(HB_START))
                LHBL <= 1'b0;
            else if (h_nxt == 9'(HB_END))
                LHBL <= 1'b1;

            if (h_nxt == hs_a)
                HS <= 1'b1;
            else if (h_nxt == hs_b)
                HS <= 1'b0;

            // Vertical flags only move on a line boundary.
            if (h_wrap) begin
                if (v_nxt == 9'(VB_START))
                    LVBL <= 1'b0;
                else if (v_nxt == 9'(VB_END))
                    LVBL <= 1'b1;

                if (v_nxt == 9'(VS_START))
                    VS <= 1'b1;
                else if (v_nxt == 9'(VS_END))
                    VS <= 1'b0;
            end

            lhbl_pipe[0] <= LHBL;
            lvbl_pipe[0] <= LVBL;
            for (int i = 1; i < DLY; i++) begin
                lhbl_pipe[i] <= lhbl_pipe[i-1];
                lvbl_pipe[i] <= lvbl_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_jtcontra_vtimer_adj.sv
// Directed bench for jtcontra_vtimer_adj. A reduced raster (48 px x 20 lines)
// keeps whole frames short; the expected values below are worked out by hand
// for these parameters.
//   line: 0..47, LHBL low 35..46, HS 30..35 (ofs 0)
//   frame: 0..19, LVBL low lines 16..19,0,1, VS lines 17,18
module tb_jtcontra_vtimer_adj;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic [3:0] hs_ofs;
    logic [8:0] hdump, vdump, vrender, vrender1;
    logic       LHBL, LVBL, LHBL_dly, LVBL_dly, HS, VS, Hinit, Vinit;
    logic [7:0] frame;

    int n_chk  = 0;
    int n_fail = 0;

    jtcontra_vtimer_adj #(
        .H_START(0), .H_END(47), .HB_START(35), .HB_END(47),
        .HS_START(30), .HS_END(36),
        .V_START(0), .V_END(19), .VB_START(16), .VB_END(2),
        .VS_START(17), .VS_END(19), .DLY(3)
    ) dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hs_ofs(hs_ofs),
        .hdump(hdump), .vdump(vdump), .vrender(vrender), .vrender1(vrender1),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .HS(HS), .VS(VS), .Hinit(Hinit), .Vinit(Vinit), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n back-to-back pixel ticks; called and returns at a negedge.
    task automatic run(input int n);
        pxl_cen = 1'b1;
        repeat (n) @(negedge clk);
        pxl_cen = 1'b0;
    endtask

    // One pixel tick followed by a 5-clock gap.
    task automatic tick_gap();
        run(1);
        repeat (5) @(negedge clk);
    endtask

    // From hdump==0, run one line and report where HS rose and fell.
    task automatic hs_line(output int rise, output int fall);
        logic prev;
        rise = -1;
        fall = -1;
        prev = HS;
        for (int k = 0; k < 48; k++) begin
            run(1);
            if (HS && !prev)  rise = int'(hdump);
            if (!HS && prev)  fall = int'(hdump);
            prev = HS;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lhbl_lo, hs_hi, lvbl_lo, vs_hi, hin, vin, fall_h, rise_h, hsr_h;
        int vr18, vr1_18, vr19, vr1_19, r, f;
        logic prev_lhbl, prev_hs;

        rst = 1'b1; pxl_cen = 1'b0; hs_ofs = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst hdump", hdump, 0);
        chk("rst vdump", vdump, 0);
        chk("rst vrender", vrender, 1);
        chk("rst vrender1", vrender1, 2);
        chk("rst LHBL", LHBL, 0);
        chk("rst LVBL", LVBL, 0);
        chk("rst HS", HS, 0);
        chk("rst VS", VS, 0);
        chk("rst Hinit", Hinit, 0);
        chk("rst frame", frame, 0);

        rst = 1'b0;
        @(negedge clk);
        run(10);
        chk("t10 hdump", hdump, 10);
        chk("t10 vdump", vdump, 0);
        chk("t10 vrender", vrender, 1);
        chk("t10 vrender1", vrender1, 2);
        chk("t10 LHBL", LHBL, 0);
        chk("t10 LVBL", LVBL, 0);
        chk("t10 HS", HS, 0);
        repeat (5) @(negedge clk);
        chk("hold hdump", hdump, 10);

        // Walk lines 1..19 sample by sample.
        run(38);
        chk("line1 start", {vdump, hdump}, {9'd1, 9'd0});
        lhbl_lo = 0; hs_hi = 0; lvbl_lo = 0; vs_hi = 0; hin = 0; vin = 0;
        fall_h = -1; rise_h = -1; hsr_h = -1;
        vr18 = -1; vr1_18 = -1; vr19 = -1; vr1_19 = -1;
        prev_lhbl = LHBL; prev_hs = HS;
        for (int i = 0; i < 19*48; i++) begin
            if (!LHBL) lhbl_lo++;
            if (HS) hs_hi++;
            if (Hinit) hin++;
            if (Vinit) vin++;
            if (hdump == 9'd0 && !LVBL) lvbl_lo++;
            if (hdump == 9'd0 && VS) vs_hi++;
            if (!LHBL && prev_lhbl) fall_h = int'(hdump);
            if (LHBL && !prev_lhbl) rise_h = int'(hdump);
            if (HS && !prev_hs) hsr_h = int'(hdump);
            if (hdump == 9'd0 && vdump == 9'd18) begin vr18 = int'(vrender); vr1_18 = int'(vrender1); end
            if (hdump == 9'd0 && vdump == 9'd19) begin vr19 = int'(vrender); vr1_19 = int'(vrender1); end
            prev_lhbl = LHBL; prev_hs = HS;
            run(1);
        end
        chk("LHBL low ticks", lhbl_lo, 19*12);
        chk("LHBL fall h", fall_h, 35);
        chk("LHBL rise h", rise_h, 47);
        chk("HS high ticks", hs_hi, 19*6);
        chk("HS rise h", hsr_h, 30);
        chk("LVBL low lines", lvbl_lo, 5);
        chk("VS high lines", vs_hi, 2);
        chk("Hinit count", hin, 19);
        chk("Vinit count", vin, 1);
        chk("vrender @18", vr18, 19);
        chk("vrender1 @18", vr1_18, 0);
        chk("vrender @19", vr19, 0);
        chk("vrender1 @19", vr1_19, 1);
        chk("wrap hdump", hdump, 0);
        chk("wrap vdump", vdump, 0);
        chk("wrap vrender1", vrender1, 2);
        chk("frame 1", frame, 1);

        // Offset changed mid-frame is ignored until the next frame.
        run(5*48);
        hs_ofs = 4'b1101;
        hs_line(r, f);
        chk("ofs-3 same frame rise", r, 30);
        chk("ofs-3 same frame fall", f, 36);
        run(14*48);
        chk("frame 2", frame, 2);
        hs_line(r, f);
        chk("ofs-3 rise", r, 27);
        chk("ofs-3 fall", f, 33);
        hs_ofs = 4'd7;
        run(19*48);
        hs_line(r, f);
        chk("ofs+7 rise", r, 37);
        chk("ofs+7 fall", f, 43);
        hs_ofs = 4'd0;

        // Delay line with gapped pixel enables; now at hdump 0 of line 1.
        run(34);
        chk("dly pre LHBL", LHBL, 1);
        chk("dly pre LHBL_dly", LHBL_dly, 1);
        tick_gap();
        chk("dly t0 LHBL", LHBL, 0);
        chk("dly t0 LHBL_dly", LHBL_dly, 1);
        tick_gap();
        chk("dly t1 LHBL_dly", LHBL_dly, 1);
        tick_gap();
        chk("dly t2 LHBL_dly", LHBL_dly, 1);
        tick_gap();
        chk("dly t3 LHBL_dly", LHBL_dly, 0);
        run(9);
        chk("dly LVBL line1", LVBL, 0);
        tick_gap();
        chk("dly LVBL rise", LVBL, 1);
        chk("dly v0 LVBL_dly", LVBL_dly, 0);
        tick_gap();
        tick_gap();
        chk("dly v2 LVBL_dly", LVBL_dly, 0);
        tick_gap();
        chk("dly v3 LVBL_dly", LVBL_dly, 1);

        // Asynchronous reset in the middle of a frame.
        run(10*48 + 17);
        chk("pre-rst pos", {vdump, hdump}, {9'd12, 9'd20});
        chk("pre-rst frame", frame, 3);
        chk("pre-rst LVBL", LVBL, 1);
        chk("pre-rst LHBL_dly", LHBL_dly, 1);
        rst = 1'b1;
        pxl_cen = 1'b1;
        #1;
        chk("arst hdump", hdump, 0);
        chk("arst vdump", vdump, 0);
        chk("arst frame", frame, 0);
        chk("arst LHBL", LHBL, 0);
        chk("arst LVBL", LVBL, 0);
        chk("arst LHBL_dly", LHBL_dly, 0);
        chk("arst vrender", vrender, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pxl_cen = 1'b0;
        @(negedge clk);
        chk("post-rst hold", hdump, 0);
        run(5);
        chk("post-rst hdump", hdump, 5);
        chk("post-rst vdump", vdump, 0);
        chk("post-rst frame", frame, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
